// File: rtl/ram_loader_pkg.sv
// ram_loader shared definitions.
// States, sizes and index limits.
package ram_loader_pkg;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int ADDR_W = WIDTH / 2 + 1;

  localparam logic [IDX_W-1:0] LAST_INDEX = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    VERIFY,
    DONE
  } state_t;

endpackage

// File: rtl/ram_loader.sv
// Streams 16 bytes into program RAM,
// reads them back and compares checksums.
module ram_loader
  import ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  inout  wire  [WIDTH-1:0]  bus,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [WIDTH-1:0]  checksum
);

  state_t            state;
  state_t            state_n;
  logic [IDX_W-1:0]  index;
  logic [WIDTH-1:0]  data_q;
  logic [WIDTH-1:0]  sum_wr;
  logic [WIDTH-1:0]  sum_rd;
  logic [WIDTH-1:0]  sum_rd_n;
  logic              drive;
  logic              last;

  assign last     = (index == LAST_INDEX);
  assign sum_rd_n = sum_rd + bus;

  assign busy     = (state != IDLE);
  assign cpu_hold = busy;
  assign bus      = drive ? data_q : {WIDTH{1'bz}};

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // index, data latch, running sums and result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index    <= '0;
      data_q   <= '0;
      sum_wr   <= '0;
      sum_rd   <= '0;
      error    <= 1'b0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            index  <= '0;
            sum_wr <= '0;
            sum_rd <= '0;
            error  <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            data_q <= in_data;
          end
        end
        WRITE: begin
          sum_wr <= sum_wr + data_q;
          index  <= last ? '0 : index + 4'd1;
        end
        VERIFY: begin
          sum_rd <= sum_rd_n;
          if (last) begin
            checksum <= sum_wr;
            error    <= (sum_rd_n != sum_wr);
          end else begin
            index <= index + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // next state and per-state strobes
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    ram_wr_en = 1'b0;
    ram_rd_en = 1'b0;
    drive     = 1'b0;
    done      = 1'b0;
    mar_addr  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        mar_addr = {1'b0, index};
        if (in_valid) begin
          state_n = WRITE;
        end
      end
      WRITE: begin
        ram_wr_en = 1'b1;
        drive     = 1'b1;
        mar_addr  = {1'b0, index};
        state_n   = last ? VERIFY : LOAD;
      end
      VERIFY: begin
        ram_rd_en = 1'b1;
        mar_addr  = {1'b0, index};
        if (last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_loader.sv
// ram_loader bench with a 16x8 RAM
// on the shared bus and a write scoreboard.
module tb_ram_loader;
  import ram_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [4:0]  mar_addr;
  logic        ram_wr_en;
  logic        ram_rd_en;
  wire  [7:0]  bus;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [7:0]  checksum;

  logic [7:0]  mem [16];
  logic        force_arm;
  logic [11:0] wq [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  wire force_bus = force_arm && ram_rd_en && (mar_addr == 5'd5);

  assign bus = force_bus ? 8'h00 : 8'hzz;
  assign bus = (ram_rd_en && !force_bus) ? mem[mar_addr[3:0]] : 8'hzz;

  ram_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mar_addr (mar_addr),
    .ram_wr_en(ram_wr_en),
    .ram_rd_en(ram_rd_en),
    .bus      (bus),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wr_en) mem[mar_addr[3:0]] <= bus;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] b [16]);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 16; i++) s = s + b[i];
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("wr_rd_excl", 32'(ram_wr_en & ram_rd_en), 0);
      chk("addr_msb", 32'(mar_addr[4]), 0);
      chk("cpu_hold", 32'(cpu_hold), 32'(busy));
      if (in_ready)
        chk("ready_state", 32'({ram_wr_en, ram_rd_en, busy}), 1);
      if (ram_wr_en) begin
        if (wq.size() == 0) begin
          chk("extra_write", 32'(mar_addr), 32'hFFFF);
        end else begin
          logic [11:0] e;
          e = wq.pop_front();
          chk("write", 32'({mar_addr[3:0], bus}), 32'(e));
        end
      end
    end
  end

  task automatic feed(input logic [7:0] b [16], input int cnt,
                      input int gapmax, input bit noise,
                      output int gaps);
    gaps = 0;
    for (int k = 0; k < cnt; k++) begin
      int n;
      int g;
      n = 0;
      while (!in_ready && n < 20) begin
        if (noise) begin
          start    = 1'b1;
          in_valid = 1'($urandom % 2);
        end
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      chk("ready_timeout", 32'(n >= 20), 0);
      g = int'($urandom_range(gapmax));
      if (g > 0) begin
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      gaps += g;
      in_valid = 1'b1;
      in_data  = b[k];
      wq.push_back({4'(k), b[k]});
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [7:0] b [16], input int gapmax,
                     input bit noise, input logic [7:0] exp_sum,
                     input logic exp_err);
    int gaps;
    int n;
    int c0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    feed(b, 16, gapmax, noise, gaps);
    n = 0;
    while (!done && n < 80) begin
      if (noise) begin
        start    = 1'b1;
        in_valid = 1'($urandom % 2);
      end
      @(negedge clk);
      n++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("done_timeout", 32'(n >= 80), 0);
    chk("latency", 32'(cyc - c0), 32'(48 + gaps));
    chk("checksum", 32'(checksum), 32'(exp_sum));
    chk("error", 32'(error), 32'(exp_err));
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("back_idle", 32'(busy), 0);
    chk("sb_empty", 32'(wq.size()), 0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("ram%0d", i), 32'(mem[i]), 32'(b[i]));
  endtask

  initial begin
    logic [7:0] p1 [16];
    logic [7:0] p2 [16];
    logic [7:0] p3 [16];
    logic [7:0] p4 [16];
    logic [7:0] p5 [16];
    logic [7:0] p6 [16];
    int g;

    for (int i = 0; i < 16; i++) begin
      p1[i] = 8'(i);
      p2[i] = 8'hFF;
      p3[i] = 8'(i * 8'h11);
      p4[i] = 8'hC3 ^ 8'(i * 7);
      p5[i] = 8'hA0 + 8'(i);
      p6[i] = ~8'(i * 3);
    end

    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    force_arm = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_wr", 32'(ram_wr_en), 0);
    chk("rst_rd", 32'(ram_rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hold", 32'(cpu_hold), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_addr", 32'(mar_addr), 0);
    chk("rst_sum", 32'(checksum), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(p1, 0, 1'b0, 8'h78, 1'b0);
    run(p2, 3, 1'b0, 8'hF0, 1'b0);

    force_arm = 1'b1;
    run(p3, 0, 1'b0, 8'hF8, 1'b1);
    force_arm = 1'b0;

    run(p4, 0, 1'b1, sum8(p4), 1'b0);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed(p5, 7, 0, 1'b0, g);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_ready", 32'(in_ready), 0);
    chk("mid_wr", 32'(ram_wr_en), 0);
    chk("mid_rd", 32'(ram_rd_en), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_hold", 32'(cpu_hold), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_error", 32'(error), 0);
    chk("mid_addr", 32'(mar_addr), 0);
    chk("mid_sum", 32'(checksum), 0);
    chk("mid_sb", 32'(wq.size()), 0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("mid_ram%0d", i), 32'(mem[i]),
          32'(i < 7 ? p5[i] : p4[i]));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_busy", 32'(busy), 0);

    run(p6, 0, 1'b0, sum8(p6), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Program loader sitting directly upstream of the 16 x 8-bit program RAM. Accepts a byte stream over a valid/ready handshake and writes it into RAM locations 0..15 through the RAM's address, write-enable and shared tri-state bus pins. It then reads all 16 words back and compares mod-256 checksums. While it runs, it asserts a hold that keeps the CPU core off the bus.

## Interface
- WIDTH, 8, data/bus width
- DEPTH, 16, words loaded per run; fixed at 16, address counter is 4 bits
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load run; sampled only in IDLE
- in_valid  in  1  stream byte available
- in_data  in  WIDTH  stream byte
- in_ready  out  1  loader accepts a byte; high only in LOAD
- mar_addr  out  WIDTH/2+1  RAM address; MSB always 0, low 4 bits = word index
- ram_wr_en  out  1  RAM write enable
- ram_rd_en  out  1  RAM read enable
- bus  inout  WIDTH  shared bus; driven by loader only in WRITE, else high-Z
- busy  out  1  high in every state except IDLE
- cpu_hold  out  1  equals busy; CPU must not drive the bus or RAM controls while high
- done  out  1  one-cycle pulse at end of run
- error  out  1  readback checksum mismatch; valid with done; holds until next accepted start
- checksum  out  WIDTH  mod-256 sum of bytes written; updated with done; holds until next accepted start

## Operation
- States: IDLE, LOAD, WRITE, VERIFY, DONE.
- IDLE: all strobes low, bus high-Z. When start=1 at the edge: clear the index, sum_wr, sum_rd and error, then go to LOAD.
- LOAD: in_ready=1 and mar_addr=index. When in_valid & in_ready at the edge: latch in_data into data_q, then go to WRITE. The loader waits indefinitely if the stream stalls.
- WRITE: bus=data_q, ram_wr_en=1, in_ready=0. At the edge, add data_q to sum_wr (mod 256).
  - If index=15: set index to 0, then go to VERIFY.
  - Otherwise: increment index, then go to LOAD.
- VERIFY: ram_rd_en=1, mar_addr=index, bus high-Z from the loader. At the edge, add bus to sum_rd.
  - If index=15: go to DONE.
  - Otherwise: increment index.
- DONE: done=1 for one cycle. checksum=sum_wr. error=(sum_rd != sum_wr). Then go to IDLE.
- Never asserted in the same cycle: ram_wr_en and ram_rd_en; a loader bus drive and ram_rd_en.
- No address wrap. Writes stop after index 15; location 0 is never rewritten within a run.
- start while busy is ignored. in_valid outside LOAD is ignored and no byte is consumed.

## Timing
- Reset values: state IDLE; in_ready, ram_wr_en, ram_rd_en, busy, cpu_hold, done, error all 0; mar_addr 0; checksum 0; bus high-Z. Internal index, data_q, sums cleared.
- Reset mid-run: return to IDLE immediately (asynchronously). Partially written RAM contents are left as-is; no done pulse.
- start accepted at edge E0 with in_valid held high:
  - byte k handshakes at edge E0+2k+1 and is written at E0+2k+2;
  - the last write is at E0+32;
  - readback edges are E0+33..E0+48;
  - done is high in the cycle after E0+48;
  - busy falls after E0+49.
- Minimum run: 49 cycles from the start edge to the done cycle. Each stall cycle on in_valid adds one cycle.
- RAM read is combinational from mar_addr/ram_rd_en, so readback data is sampled in the same cycle it is addressed.

## Structure
- Shared package holds:
  - the state enum (IDLE, LOAD, WRITE, VERIFY, DONE);
  - DEPTH=16, the index width (4) and the address width (WIDTH/2+1);
  - the LAST_INDEX constant (15).
- Single module with no sub-modules. The checksum adders and index counter are inline.
- The bench instantiates the program RAM on the same bus, with a pulldown-free tri-state check.

## Test plan
- Reset, then start; stream bytes 0x00..0x0F back-to-back -> RAM[i]=i, done in the cycle after start edge +48, checksum=0x78, error=0.
- Stream all 0xFF with random 0-3 cycle in_valid gaps -> checksum=0xF0, error=0, cycle count = 49 + total gap cycles, in_ready never high outside LOAD.
- Bench forces bus to 0x00 during the VERIFY read of index 5 (data 0x55 loaded) -> done with error=1, checksum unchanged (sum of written bytes).
- Assert start again mid-run and toggle in_valid during WRITE/VERIFY -> no restart, no extra bytes consumed, RAM contents and checksum match the single-run result.
- Assert rst after the 7th write -> all outputs at reset values immediately, bus high-Z, RAM[0..6] written, RAM[7..15] untouched. A following start performs a full clean run.
- Every cycle: ram_wr_en & ram_rd_en never both 1, no bus X/contention, mar_addr MSB always 0.
